// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the RV32I 5-stage pipeline: load-use bubbles, dmem wait freeze, branch redirect.
// Optional macro HAZARD_PERF_CNT_EN enables the lu_stall_cnt / flush_cnt / wait_cnt performance counters.
module hazard_control_unit #(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_data_ID,
  input  logic [31:0]      inst_data_EX,
  input  logic             memread_EX,
  input  logic             branch_taken_EX,
  input  logic             dmem_busy,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_MEM,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             pc_redirect,
  output logic             timeout_err,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [15:0] TIMEOUT_L = 16'(WAIT_TIMEOUT);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

  state_t      state_r, state_nxt_s;
  logic        pend_flush_r, pend_flush_nxt_s;
  logic [15:0] wait_ctr_r;
  logic        timeout_r;
  logic        timeout_hit_s;

  logic [4:0]  rd_ex_s, rs1_id_s, rs2_id_s;
  logic [6:0]  opcode_id_s;
  logic        load_use_s;

  logic        stall_all_s;
  logic        lu_bubble_s;
  logic        redirect_s;

  assign rd_ex_s     = inst_data_EX[11:7];
  assign rs1_id_s    = inst_data_ID[19:15];
  assign rs2_id_s    = inst_data_ID[24:20];
  assign opcode_id_s = inst_data_ID[6:0];

  assign load_use_s = memread_EX && (rd_ex_s != 5'd0) &&
                      ((uses_rs1(opcode_id_s) && (rd_ex_s == rs1_id_s)) ||
                       (uses_rs2(opcode_id_s) && (rd_ex_s == rs2_id_s)));

  // State and pending-flush register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_RUN;
      pend_flush_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pend_flush_r <= pend_flush_nxt_s;
    end
  end

  // Next-state and hazard action selection
  always_comb begin
    state_nxt_s      = state_r;
    pend_flush_nxt_s = pend_flush_r;
    stall_all_s      = 1'b0;
    lu_bubble_s      = 1'b0;
    redirect_s       = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (dmem_busy) begin
          stall_all_s      = 1'b1;
          pend_flush_nxt_s = branch_taken_EX;
          state_nxt_s      = ST_WAIT;
        end else if (branch_taken_EX) begin
          redirect_s = 1'b1;
        end else if (load_use_s) begin
          lu_bubble_s = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (dmem_busy) begin
          stall_all_s      = 1'b1;
          pend_flush_nxt_s = pend_flush_r | branch_taken_EX;
        end else begin
          if (pend_flush_r || branch_taken_EX) begin
            redirect_s = 1'b1;
          end else if (load_use_s) begin
            lu_bubble_s = 1'b1;
          end else begin
            redirect_s = 1'b0;
          end
          pend_flush_nxt_s = 1'b0;
          state_nxt_s      = ST_RUN;
        end
      end
      default: begin
        state_nxt_s      = ST_RUN;
        pend_flush_nxt_s = 1'b0;
      end
    endcase
  end

  // Consecutive-busy counter (saturating) and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_ctr_r <= 16'd0;
      timeout_r  <= 1'b0;
    end else begin
      if (dmem_busy) begin
        wait_ctr_r <= (wait_ctr_r == TIMEOUT_L) ? wait_ctr_r : wait_ctr_r + 16'd1;
      end else begin
        wait_ctr_r <= 16'd0;
      end
      timeout_r <= timeout_r | timeout_hit_s;
    end
  end

  // The flag is visible during the busy cycle that reaches the limit.
  assign timeout_hit_s = dmem_busy && (wait_ctr_r >= (TIMEOUT_L - 16'd1));

  // Outputs drop the moment reset asserts, even while still frozen.
  assign stall_PC     = rst_n & (stall_all_s | lu_bubble_s);
  assign stall_IF_ID  = rst_n & (stall_all_s | lu_bubble_s);
  assign stall_ID_EX  = rst_n & stall_all_s;
  assign stall_EX_MEM = rst_n & stall_all_s;
  assign flush_IF_ID  = rst_n & redirect_s;
  assign flush_ID_EX  = rst_n & (redirect_s | lu_bubble_s);
  assign pc_redirect  = rst_n & redirect_s;
  assign timeout_err  = rst_n & (timeout_r | timeout_hit_s);

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [CNT_W-1:0] lu_cnt_r, flush_cnt_r, wait_cnt_r;

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_r    <= '0;
      flush_cnt_r <= '0;
      wait_cnt_r  <= '0;
    end else begin
      if (lu_bubble_s) begin
        lu_cnt_r <= sat_inc(lu_cnt_r);
      end
      if (redirect_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
      if (dmem_busy) begin
        wait_cnt_r <= sat_inc(wait_cnt_r);
      end
    end
  end

  assign lu_stall_cnt = lu_cnt_r;
  assign flush_cnt    = flush_cnt_r;
  assign wait_cnt     = wait_cnt_r;
`else
  assign lu_stall_cnt = '0;
  assign flush_cnt    = '0;
  assign wait_cnt     = '0;
`endif

  logic unused_s;
  assign unused_s = ^{inst_data_ID[31:25], inst_data_ID[14:7], inst_data_EX[31:12], inst_data_EX[6:0]};

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit (WAIT_TIMEOUT overridden to 4).
module tb_hazard_control_unit;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] LW_X5   = 32'h0000_A283;
  localparam logic [31:0] LW_X0   = 32'h0000_A003;
  localparam logic [31:0] ADD_X5  = 32'h0072_8333;
  localparam logic [31:0] ADD_X0  = 32'h0000_0333;
  localparam logic [31:0] LUI_X6  = 32'h0002_8337;
  localparam logic [31:0] SW_X5   = 32'h0051_2023;
  localparam logic [31:0] ADDI_X1 = 32'h0050_8313;

  // {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, flush_IF_ID, flush_ID_EX, pc_redirect, timeout_err}
  localparam logic [7:0] O_NONE   = 8'h00;
  localparam logic [7:0] O_LU     = 8'hC4;
  localparam logic [7:0] O_REDIR  = 8'h0E;
  localparam logic [7:0] O_FREEZE = 8'hF0;
  localparam logic [7:0] O_TO     = 8'h01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_data_ID, inst_data_EX;
  logic        memread_EX, branch_taken_EX, dmem_busy;
  logic        stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
  logic        flush_IF_ID, flush_ID_EX, pc_redirect, timeout_err;
  logic [31:0] lu_stall_cnt, flush_cnt, wait_cnt;
  logic [7:0]  outs;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_control_unit #(.WAIT_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_data_ID(inst_data_ID), .inst_data_EX(inst_data_EX),
    .memread_EX(memread_EX), .branch_taken_EX(branch_taken_EX), .dmem_busy(dmem_busy),
    .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_MEM(stall_EX_MEM), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .pc_redirect(pc_redirect), .timeout_err(timeout_err),
    .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
                 flush_IF_ID, flush_ID_EX, pc_redirect, timeout_err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] id, input logic [31:0] ex,
                       input logic mr, input logic br, input logic busy);
    inst_data_ID    = id;
    inst_data_EX    = ex;
    memread_EX      = mr;
    branch_taken_EX = br;
    dmem_busy       = busy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    #10;
    chk("reset_outs", {24'd0, outs}, {24'd0, O_NONE});
    chk("reset_lu_cnt", lu_stall_cnt, 32'd0);
    chk("reset_wait_cnt", wait_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_outs", {24'd0, outs}, {24'd0, O_NONE});

    // load-use: lw x5 in EX, add x6,x5,x7 in ID
    drive(ADD_X5, LW_X5, 1'b1, 1'b0, 1'b0);
    chk("lu_bubble", {24'd0, outs}, {24'd0, O_LU});
    tick();
    drive(ADD_X5, NOP, 1'b0, 1'b0, 1'b0);
    chk("lu_after_bubble", {24'd0, outs}, {24'd0, O_NONE});
    chk("lu_cnt_1", lu_stall_cnt, pc(1));

    drive(ADD_X0, LW_X0, 1'b1, 1'b0, 1'b0);
    chk("lw_x0_no_stall", {24'd0, outs}, {24'd0, O_NONE});
    drive(LUI_X6, LW_X5, 1'b1, 1'b0, 1'b0);
    chk("lui_no_stall", {24'd0, outs}, {24'd0, O_NONE});
    drive(ADDI_X1, LW_X5, 1'b1, 1'b0, 1'b0);
    chk("itype_rs2_field_ignored", {24'd0, outs}, {24'd0, O_NONE});
    drive(SW_X5, LW_X5, 1'b1, 1'b0, 1'b0);
    chk("store_rs2_stall", {24'd0, outs}, {24'd0, O_LU});
    tick();
    chk("lu_cnt_2", lu_stall_cnt, pc(2));

    // branch beats load-use
    drive(ADD_X5, LW_X5, 1'b1, 1'b1, 1'b0);
    chk("branch_over_lu", {24'd0, outs}, {24'd0, O_REDIR});
    tick();
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    chk("flush_cnt_1", flush_cnt, pc(1));
    chk("lu_cnt_unchanged", lu_stall_cnt, pc(2));

    // 3-cycle dmem wait with branch in the first cycle
    drive(NOP, NOP, 1'b0, 1'b1, 1'b1);
    chk("busy_c1", {24'd0, outs}, {24'd0, O_FREEZE});
    tick();
    drive(NOP, NOP, 1'b0, 1'b0, 1'b1);
    chk("busy_c2", {24'd0, outs}, {24'd0, O_FREEZE});
    tick();
    chk("busy_c3", {24'd0, outs}, {24'd0, O_FREEZE});
    tick();
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    chk("pending_redirect", {24'd0, outs}, {24'd0, O_REDIR});
    tick();
    chk("after_redirect", {24'd0, outs}, {24'd0, O_NONE});
    chk("wait_cnt_3", wait_cnt, pc(3));
    chk("flush_cnt_2", flush_cnt, pc(2));

    // 6-cycle wait: timeout on busy cycle 4
    drive(NOP, NOP, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("to_busy_c%0d", c), {24'd0, outs},
          {24'd0, (c >= 4) ? (O_FREEZE | O_TO) : O_FREEZE});
      tick();
    end
    drive(ADD_X5, LW_X5, 1'b1, 1'b0, 1'b0);
    chk("wait_release_lu", {24'd0, outs}, {24'd0, O_LU | O_TO});
    tick();
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    chk("timeout_sticky", {24'd0, outs}, {24'd0, O_TO});
    chk("wait_cnt_9", wait_cnt, pc(9));
    chk("lu_cnt_3", lu_stall_cnt, pc(3));
    tick();
    chk("timeout_still_sticky", {24'd0, outs}, {24'd0, O_TO});

    rst_n = 1'b0;
    #1;
    chk("reset_clears_timeout", {24'd0, outs}, {24'd0, O_NONE});
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {24'd0, outs}, {24'd0, O_NONE});

    // reset during WAIT with a pending flush
    drive(NOP, NOP, 1'b0, 1'b1, 1'b1);
    chk("rw_busy_c1", {24'd0, outs}, {24'd0, O_FREEZE});
    tick();
    drive(NOP, NOP, 1'b0, 1'b0, 1'b1);
    chk("rw_busy_c2", {24'd0, outs}, {24'd0, O_FREEZE});
    rst_n = 1'b0;
    #1;
    chk("rw_reset_immediate", {24'd0, outs}, {24'd0, O_NONE});
    chk("rw_reset_wait_cnt", wait_cnt, 32'd0);
    tick();
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("rw_release_no_flush", {24'd0, outs}, {24'd0, O_NONE});
    tick();
    chk("rw_next_no_flush", {24'd0, outs}, {24'd0, O_NONE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
